// File: rtl/gate_reduce_seq.sv
// gate_reduce_seq: folds a multi-beat frame of WIDTH-bit words with a
// run-time selected gate op (AND/OR/XOR and their inversions) and emits one
// result word per frame over a valid/ready stream.
module gate_reduce_seq #(
  parameter int WIDTH  = 8,
  parameter int MAXLEN = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [2:0]                   op,
  input  logic [WIDTH-1:0]             A,
  input  logic                         in_valid,
  input  logic                         in_last,
  output logic                         in_ready,
  output logic [WIDTH-1:0]             Y,
  output logic [$clog2(MAXLEN+1)-1:0]  beats,
  output logic                         ovf,
  output logic                         out_valid,
  input  logic                         out_ready
);

  localparam int CW = $clog2(MAXLEN + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // Per-beat fold uses only the base gate; the inverting ops share it and
  // apply their inversion once to the final result.
  function automatic logic [WIDTH-1:0] fold_word(input logic [2:0] sel,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    case (sel)
      3'd1, 3'd4: r = a | b;
      3'd2, 3'd5: r = a ^ b;
      default:    r = a & b;
    endcase
    return r;
  endfunction

  // Converts the accumulated base-gate value into the frame result.
  function automatic logic [WIDTH-1:0] finalize(input logic [2:0] sel,
                                                input logic [WIDTH-1:0] a);
    logic [WIDTH-1:0] r;
    case (sel)
      3'd3, 3'd4, 3'd5: r = ~a;
      default:          r = a;
    endcase
    return r;
  endfunction

  state_t            state_r;
  logic [WIDTH-1:0]  acc_r;
  logic [2:0]        op_r;
  logic [CW-1:0]     cnt_r;
  logic [WIDTH-1:0]  y_r;
  logic [CW-1:0]     beats_r;
  logic              ovf_r;
  logic              out_valid_r;

  logic              in_ready_s;
  logic              accept_s;
  logic [WIDTH-1:0]  acc_next_s;
  logic [CW-1:0]     cnt_next_s;
  logic              close_s;

  // Ready depends only on state; next accumulator/count for the ACC state.
  always_comb begin
    in_ready_s = 1'b0;
    case (state_r)
      ST_IDLE: in_ready_s = 1'b1;
      ST_ACC:  in_ready_s = 1'b1;
      default: in_ready_s = 1'b0;
    endcase
    accept_s   = in_valid & in_ready_s;
    acc_next_s = fold_word(op_r, acc_r, A);
    cnt_next_s = cnt_r + CW'(1);
    if (in_last || (cnt_next_s == CW'(MAXLEN))) begin
      close_s = 1'b1;
    end else begin
      close_s = 1'b0;
    end
  end

  // Frame FSM: accumulate beats, latch the result, hold until consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      acc_r       <= '0;
      op_r        <= 3'd0;
      cnt_r       <= '0;
      y_r         <= '0;
      beats_r     <= '0;
      ovf_r       <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            acc_r <= A;
            op_r  <= op;
            cnt_r <= CW'(1);
            if (in_last) begin
              state_r     <= ST_HOLD;
              y_r         <= finalize(op, A);
              beats_r     <= CW'(1);
              ovf_r       <= 1'b0;
              out_valid_r <= 1'b1;
            end else begin
              state_r <= ST_ACC;
            end
          end
        end
        ST_ACC: begin
          if (accept_s) begin
            acc_r <= acc_next_s;
            cnt_r <= cnt_next_s;
            if (close_s) begin
              state_r     <= ST_HOLD;
              y_r         <= finalize(op_r, acc_next_s);
              beats_r     <= cnt_next_s;
              ovf_r       <= ~in_last;
              out_valid_r <= 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
            ovf_r       <= 1'b0;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          out_valid_r <= 1'b0;
          ovf_r       <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_s;
  assign Y         = y_r;
  assign beats     = beats_r;
  assign ovf       = ovf_r;
  assign out_valid = out_valid_r;

endmodule

// File: tb/tb_gate_reduce_seq.sv
// Testbench for gate_reduce_seq: table vectors, directed corner sequences and
// randomized traffic against a frame-level reference model.
module tb_gate_reduce_seq;

  localparam int WIDTH  = 8;
  localparam int MAXLEN = 16;
  localparam int CW     = $clog2(MAXLEN + 1);

  logic             clk;
  logic             rst;
  logic [2:0]       op;
  logic [WIDTH-1:0] A;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic [WIDTH-1:0] Y;
  logic [CW-1:0]    beats;
  logic             ovf;
  logic             out_valid;
  logic             out_ready;

  int n_checks = 0;
  int n_errors = 0;

  gate_reduce_seq #(.WIDTH(WIDTH), .MAXLEN(MAXLEN)) dut (
    .clk(clk), .rst(rst), .op(op), .A(A), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .Y(Y), .beats(beats),
    .ovf(ovf), .out_valid(out_valid), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: words of the open frame and the pending result.
  logic [WIDTH-1:0] m_words [MAXLEN];
  int               m_n;
  logic [2:0]       m_op;
  logic             m_pending;
  logic [WIDTH-1:0] m_y;
  int               m_beats;
  logic             m_ovf;

  typedef struct {
    logic             v;
    logic             last;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic             ordy;
    logic             ov;
    logic [WIDTH-1:0] y;
    int               beats;
    logic             ovf;
    logic             rdy;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-bit definition: AND = all ones, OR = any one, XOR = odd count.
  function automatic logic [WIDTH-1:0] ref_result(input logic [2:0] o, input int n);
    logic [WIDTH-1:0] r;
    for (int b = 0; b < WIDTH; b++) begin
      int ones;
      ones = 0;
      for (int i = 0; i < n; i++) ones += int'(m_words[i][b]);
      case (o)
        3'd1, 3'd4: r[b] = (ones > 0);
        3'd2, 3'd5: r[b] = (ones % 2) == 1;
        default:    r[b] = (ones == n);
      endcase
      if (o == 3'd3 || o == 3'd4 || o == 3'd5) r[b] = ~r[b];
    end
    return r;
  endfunction

  // One clock: check ready, advance model at the edge, check outputs after.
  task automatic cycle();
    check("in_ready", {31'd0, in_ready}, {31'd0, ~m_pending});
    @(posedge clk);
    if (rst) begin
      m_n = 0;
      m_pending = 1'b0;
    end else if (m_pending) begin
      if (out_ready) m_pending = 1'b0;
    end else if (in_valid) begin
      if (m_n == 0) m_op = op;
      m_words[m_n] = A;
      m_n++;
      if (in_last || m_n == MAXLEN) begin
        m_pending = 1'b1;
        m_y = ref_result(m_op, m_n);
        m_beats = m_n;
        m_ovf = ~in_last;
        m_n = 0;
      end
    end
    #1;
    check("out_valid", {31'd0, out_valid}, {31'd0, m_pending});
    if (m_pending) begin
      check("Y", {24'd0, Y}, {24'd0, m_y});
      check("beats", {27'd0, beats}, 32'(m_beats));
      check("ovf", {31'd0, ovf}, {31'd0, m_ovf});
    end
  endtask

  // Present one beat and keep it asserted until the block accepts it.
  task automatic send_beat(input logic [2:0] o, input logic [WIDTH-1:0] a, input logic last);
    logic taken;
    taken = 1'b0;
    op = o; A = a; in_last = last; in_valid = 1'b1;
    for (int k = 0; k < 20 && !taken; k++) begin
      taken = ~m_pending;
      cycle();
    end
    if (!taken) begin
      n_checks++;
      n_errors++;
      $display("FAIL send_timeout: beat %0h not accepted within 20 cycles", a);
    end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  initial begin
    rst = 1'b1; op = 3'd0; A = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    m_n = 0; m_op = 3'd0; m_pending = 1'b0; m_y = '0; m_beats = 0; m_ovf = 1'b0;

    // Reset state
    @(posedge clk); @(posedge clk); #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_Y", {24'd0, Y}, 32'd0);
    check("rst_beats", {27'd0, beats}, 32'd0);
    check("rst_ovf", {31'd0, ovf}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst = 1'b0;

    // Table: AND 3-beat, NAND single, XNOR 2-beat, op switch mid-frame
    vecs[0]  = '{1'b1, 1'b0, 3'd0, 8'hF0, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b1};
    vecs[1]  = '{1'b1, 1'b0, 3'd0, 8'h3C, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b1};
    vecs[2]  = '{1'b1, 1'b1, 3'd0, 8'hFF, 1'b1, 1'b1, 8'h30, 3, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 1'b1, 3'd3, 8'hA5, 1'b1, 1'b1, 8'h5A, 1, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b1};
    vecs[6]  = '{1'b1, 1'b0, 3'd5, 8'h0F, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 1'b1, 3'd5, 8'hFF, 1'b1, 1'b1, 8'h0F, 2, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 3'd0, 8'hF0, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b1};
    vecs[10] = '{1'b1, 1'b1, 3'd1, 8'h0F, 1'b1, 1'b1, 8'h00, 2, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b1};
    for (int i = 0; i < 12; i++) begin
      in_valid = vecs[i].v; in_last = vecs[i].last; op = vecs[i].op;
      A = vecs[i].a; out_ready = vecs[i].ordy;
      cycle();
      check($sformatf("vec%0d_out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].ov});
      check($sformatf("vec%0d_in_ready", i), {31'd0, in_ready}, {31'd0, vecs[i].rdy});
      if (vecs[i].ov) begin
        check($sformatf("vec%0d_Y", i), {24'd0, Y}, {24'd0, vecs[i].y});
        check($sformatf("vec%0d_beats", i), {27'd0, beats}, 32'(vecs[i].beats));
        check($sformatf("vec%0d_ovf", i), {31'd0, ovf}, {31'd0, vecs[i].ovf});
      end
    end
    in_valid = 1'b0; in_last = 1'b0;

    // Forced close at MAXLEN, then the 17th word forms its own frame
    out_ready = 1'b1;
    for (int i = 0; i < MAXLEN; i++) send_beat(3'd2, 8'h01, 1'b0);
    check("ovf_frame_Y", {24'd0, Y}, 32'h00);
    check("ovf_frame_beats", {27'd0, beats}, 32'd16);
    check("ovf_frame_ovf", {31'd0, ovf}, 32'd1);
    send_beat(3'd2, 8'h01, 1'b1);
    check("post_ovf_Y", {24'd0, Y}, 32'h01);
    check("post_ovf_beats", {27'd0, beats}, 32'd1);
    check("post_ovf_ovf", {31'd0, ovf}, 32'd0);
    cycle();

    // in_last exactly on beat MAXLEN closes normally
    for (int i = 0; i < MAXLEN; i++) send_beat(3'd1, 8'(1 << (i % 8)), i == MAXLEN - 1);
    check("maxlen_last_Y", {24'd0, Y}, 32'hFF);
    check("maxlen_last_beats", {27'd0, beats}, 32'd16);
    check("maxlen_last_ovf", {31'd0, ovf}, 32'd0);
    cycle();

    // Backpressure: result held, extra beats ignored
    send_beat(3'd1, 8'h01, 1'b0);
    out_ready = 1'b0;
    send_beat(3'd1, 8'h02, 1'b1);
    in_valid = 1'b1; A = 8'hFF; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("hold_Y", {24'd0, Y}, 32'h03);
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
      check("hold_out_valid", {31'd0, out_valid}, 32'd1);
    end
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    cycle();
    check("release_out_valid", {31'd0, out_valid}, 32'd0);
    check("release_in_ready", {31'd0, in_ready}, 32'd1);

    // Reset mid-frame discards the partial frame
    send_beat(3'd0, 8'h0F, 1'b0);
    send_beat(3'd0, 8'h3C, 1'b0);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    cycle();
    check("midrst_out_valid2", {31'd0, out_valid}, 32'd0);
    send_beat(3'd0, 8'hAA, 1'b1);
    check("after_rst_Y", {24'd0, Y}, 32'hAA);
    check("after_rst_beats", {27'd0, beats}, 32'd1);
    cycle();

    // Randomized traffic: short frames, then long frames reaching MAXLEN
    for (int i = 0; i < 4000; i++) begin
      rst       = ($urandom_range(0, 299) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      op        = 3'($urandom_range(0, 7));
      A         = WIDTH'($urandom);
      in_last   = (i < 2000) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 39) == 0);
      out_ready = ($urandom_range(0, 1) == 1);
      cycle();
    end
    rst = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
